// File: rtl/hamming_tx_encoder.sv
// rtl/hamming_tx_encoder.sv - Hamming(7,4) encoder with holding register, LSB-first serialiser and error injection
module hamming_tx_encoder #(
   parameter int GAP_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_data,
   input  logic        select,
   input  logic        inj_en,
   input  logic [2:0]  inj_pos,
   output logic        tx_bit,
   output logic        tx_valid,
   output logic        tx_sof,
   output logic        busy,
   output logic [15:0] frame_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Last value of the gap counter; only meaningful when GAP_CYCLES > 0.
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t      state, state_nx;
   logic        hold_full;
   logic [6:0]  hold_cw;
   logic [6:0]  shift_reg, shift_nx;
   logic [2:0]  count, count_nx;
   logic [3:0]  gap_cnt, gap_nx;
   logic [15:0] frame_nx;
   logic        load;
   logic        accept;
   logic        p1, p2, p4;
   logic [6:0]  enc_cw;

   // Codeword for the word on the input: parity, odd-mode inversion, then optional bit flip.
   always_comb begin
      p1     = in_data[0] ^ in_data[1] ^ in_data[3] ^ select;
      p2     = in_data[0] ^ in_data[2] ^ in_data[3] ^ select;
      p4     = in_data[1] ^ in_data[2] ^ in_data[3] ^ select;
      enc_cw = {in_data[3], in_data[2], in_data[1], p4, in_data[0], p2, p1};
      if (inj_en && (inj_pos != 3'd7)) begin
         enc_cw[inj_pos] = ~enc_cw[inj_pos];
      end
   end

   // The holding register empties into the shifter only from IDLE, so a new word may land in the same cycle.
   assign load     = (state == IDLE) && hold_full;
   assign in_ready = rst_n && (!hold_full || load);
   assign accept   = in_valid && in_ready;
   assign busy     = hold_full || (state != IDLE);

   // Next-state, shifter/counter updates and serial outputs.
   always_comb begin
      state_nx = state;
      shift_nx = shift_reg;
      count_nx = count;
      gap_nx   = gap_cnt;
      frame_nx = frame_count;
      tx_valid = 1'b0;
      tx_bit   = 1'b0;
      tx_sof   = 1'b0;
      case (state)
         IDLE: begin
            if (hold_full) begin
               shift_nx = hold_cw;
               count_nx = 3'd0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            tx_valid = 1'b1;
            tx_bit   = shift_reg[0];
            tx_sof   = (count == 3'd0);
            shift_nx = {1'b0, shift_reg[6:1]};
            count_nx = count + 3'd1;
            if (count == 3'd6) begin
               count_nx = 3'd0;
               gap_nx   = 4'd0;
               frame_nx = frame_count + 16'd1;
               state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nx = IDLE;
            end else begin
               gap_nx = gap_cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, datapath and holding-register update; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         shift_reg   <= 7'd0;
         count       <= 3'd0;
         gap_cnt     <= 4'd0;
         frame_count <= 16'd0;
         hold_full   <= 1'b0;
         hold_cw     <= 7'd0;
      end else begin
         state       <= state_nx;
         shift_reg   <= shift_nx;
         count       <= count_nx;
         gap_cnt     <= gap_nx;
         frame_count <= frame_nx;
         if (accept) begin
            hold_cw   <= enc_cw;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule

// File: doc/hamming_tx_encoder.md
Name: hamming_tx_encoder

Overview:
Transmit-side Hamming(7,4) encoder that produces the codewords consumed by the team's Hamming decoder. Accepts 4-bit data words on a valid/ready interface and computes parity using a per-word even/odd select. It serialises each 7-bit codeword LSB-first onto a framed bit stream. A one-word holding register decouples the input from the serialiser, and an error-injection hook flips a chosen codeword bit so the decoder's correction path can be exercised.

Parameters:
GAP_CYCLES, 0, extra idle cycles inserted after each frame before the next frame may start (0..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  data word offered
in_ready  output  1  word accepted when in_valid && in_ready
in_data  input  4  data d3..d0
select  input  1  parity mode sampled with word: 0 even, 1 odd
inj_en  input  1  error injection enable, sampled with word
inj_pos  input  3  codeword bit to flip (0..6); 7 = no flip
tx_bit  output  1  serial codeword bit
tx_valid  output  1  tx_bit is a codeword bit
tx_sof  output  1  high with bit 0 of each frame
busy  output  1  holding register full or frame/gap in progress
frame_count  output  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Codeword layout c[6:0] = {d3, d2, d1, p4, d0, p2, p1}.
- Even parity: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3. Odd parity (select=1): all three parity bits inverted.
- Injection: if inj_en and inj_pos<=6, c[inj_pos] is inverted after parity is computed. inj_pos=7 or inj_en=0 leaves the codeword unchanged.
- Codeword is computed at acceptance and stored in the holding register (hold_full flag). select, inj_en and inj_pos matter only in the accept cycle.
- in_ready = !hold_full || load. load is the IDLE-state transfer of the holding register into the shifter, so accept and load can occur in the same cycle.
- FSM states:
  - IDLE: if hold_full, load the shifter, clear or refill hold, bit counter = 0, go to SHIFT.
  - SHIFT: tx_valid=1, tx_bit=shift[0], tx_sof=(count==0). Shift right each cycle. After count 6: increment frame_count; go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: tx_valid=0 for GAP_CYCLES cycles, then IDLE.
- Latency: word accepted in cycle T appears with tx_sof in cycle T+2 if the FSM was idle.
- Frame spacing: the minimum spacing between frames is 1+GAP_CYCLES cycles with tx_valid low.
- The 7 tx_valid cycles of a frame are contiguous. No back-pressure exists on the serial side.
- tx_bit=0 and tx_sof=0 whenever tx_valid=0.
- busy = hold_full || state!=IDLE.
- Reset (rst_n low at a rising edge): state=IDLE, hold_full=0, shifter=0, count=0, frame_count=0, tx_valid=tx_bit=tx_sof=0, busy=0.
  - in_ready is 0 while rst_n is low and 1 in the first cycle after release.
  - Reset mid-frame aborts the frame: no partial completion and no frame_count increment.
- If in_valid is held with the holding register full and the shifter busy, the word waits; no data is dropped or duplicated.

Test Plan:
- Even encode: in_data=4'b1011, select=0, inj_en=0 -> c=7'h55; tx_bit sequence 1,0,1,0,1,0,1, tx_sof on first bit at T+2, frame_count=1.
- Odd encode: in_data=4'b1011, select=1 -> c=7'h5E (bits 0,1,1,1,1,0,1). Then in_data=0, select=1 -> 7'h0B; in_data=0, select=0 -> 7'h00.
- Injection: in_data=4'b1011, select=0, inj_en=1, inj_pos=2 -> 7'h51. Same with inj_pos=7 -> 7'h55.
- Back-to-back with in_valid held high for 3 words, GAP_CYCLES=0 -> frames separated by exactly 1 idle cycle, in_ready deasserts while hold is full, no word lost, frame_count=3.
- GAP_CYCLES=3 -> exactly 4 tx_valid-low cycles between consecutive frames.
- Reset asserted at bit 4 of a frame -> next cycle all outputs 0 and frame_count=0. A word accepted after release is emitted correctly.
